// File: rtl/somador_matrizes_seq.sv
// Sequential element-wise signed matrix add/subtract, LANES elements per clock,
// with optional saturation, active sub-matrix size and start/busy/done handshake.
module somador_matrizes_seq #(
    parameter int ELEM_W = 8,
    parameter int DIM    = 5,
    parameter int LANES  = 5
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         op,
    input  logic                         saturar,
    input  logic [$clog2(DIM+1)-1:0]     tamanho,
    input  logic [ELEM_W*DIM*DIM-1:0]    matriz_entrada_a,
    input  logic [ELEM_W*DIM*DIM-1:0]    matriz_entrada_b,
    output logic [ELEM_W*DIM*DIM-1:0]    matriz_resultado,
    output logic                         busy,
    output logic                         done,
    output logic                         overflow
);

    localparam int TOTAL  = DIM * DIM;
    localparam int FLAT_W = ELEM_W * TOTAL;
    localparam int TAM_W  = $clog2(DIM + 1);
    localparam int CNT_W  = $clog2(TOTAL + LANES + 1);
    localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(TOTAL);
    localparam logic [CNT_W-1:0] LANES_C = CNT_W'(LANES);
    localparam logic [TAM_W-1:0] DIM_C   = TAM_W'(DIM);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [FLAT_W-1:0]   a_q, a_d;
    logic [FLAT_W-1:0]   b_q, b_d;
    logic                op_q, op_d;
    logic                sat_q, sat_d;
    logic [FLAT_W-1:0]   res_q, res_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                ovf_q, ovf_d;

    logic [TAM_W-1:0]    n_s;
    logic [FLAT_W-1:0]   mask_s;
    logic [CNT_W-1:0]    idx_s;
    logic [ELEM_W:0]     lane_s;

    // Returns {overflow, result} for one element; arithmetic at ELEM_W+1 bits
    function automatic logic [ELEM_W:0] elem_op(
        input logic [ELEM_W-1:0] a,
        input logic [ELEM_W-1:0] b,
        input logic              sub,
        input logic              sat
    );
        logic [ELEM_W:0]   ext;
        logic              ovf;
        logic [ELEM_W-1:0] res;
        if (sub) begin
            ext = {a[ELEM_W-1], a} - {b[ELEM_W-1], b};
        end else begin
            ext = {a[ELEM_W-1], a} + {b[ELEM_W-1], b};
        end
        ovf = ext[ELEM_W] ^ ext[ELEM_W-1];
        if (ovf && sat) begin
            if (ext[ELEM_W]) begin
                res = {1'b1, {(ELEM_W-1){1'b0}}};
            end else begin
                res = {1'b0, {(ELEM_W-1){1'b1}}};
            end
        end else begin
            res = ext[ELEM_W-1:0];
        end
        return {ovf, res};
    endfunction

    // Next-state, operand latch and per-lane element computation
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        sat_d   = sat_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        idx_s   = {CNT_W{1'b0}};
        lane_s  = {(ELEM_W+1){1'b0}};
        mask_s  = {FLAT_W{1'b0}};

        if ((tamanho == {TAM_W{1'b0}}) || (tamanho > DIM_C)) begin
            n_s = DIM_C;
        end else begin
            n_s = tamanho;
        end

        // Inactive operands are zeroed at latch time, so they produce 0 and never overflow
        for (int c = 0; c < DIM; c++) begin
            for (int r = 0; r < DIM; r++) begin
                if ((TAM_W'(r) < n_s) && (TAM_W'(c) < n_s)) begin
                    mask_s[ELEM_W*(r + DIM*c) +: ELEM_W] = {ELEM_W{1'b1}};
                end else begin
                    mask_s[ELEM_W*(r + DIM*c) +: ELEM_W] = {ELEM_W{1'b0}};
                end
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CALC;
                    a_d     = matriz_entrada_a & mask_s;
                    b_d     = matriz_entrada_b & mask_s;
                    op_d    = op;
                    sat_d   = saturar;
                    res_d   = {FLAT_W{1'b0}};
                    ovf_d   = 1'b0;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                for (int l = 0; l < LANES; l++) begin
                    idx_s = cnt_q + CNT_W'(l);
                    if (idx_s < TOTAL_C) begin
                        lane_s = elem_op(a_q[ELEM_W*idx_s +: ELEM_W],
                                         b_q[ELEM_W*idx_s +: ELEM_W], op_q, sat_q);
                        res_d[ELEM_W*idx_s +: ELEM_W] = lane_s[ELEM_W-1:0];
                        ovf_d = ovf_d | lane_s[ELEM_W];
                    end else begin
                        lane_s = {(ELEM_W+1){1'b0}};
                    end
                end
                cnt_d = cnt_q + LANES_C;
                if ((cnt_q + LANES_C) >= TOTAL_C) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_CALC;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_CALC);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            a_q     <= {FLAT_W{1'b0}};
            b_q     <= {FLAT_W{1'b0}};
            op_q    <= 1'b0;
            sat_q   <= 1'b0;
            res_q   <= {FLAT_W{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            sat_q   <= sat_d;
            res_q   <= res_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign matriz_resultado = res_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign overflow         = ovf_q;

endmodule

// File: tb/tb_somador_matrizes_seq.sv
// Scoreboard bench for somador_matrizes_seq: stimulus pushes model results, a monitor checks on done.
module tb_somador_matrizes_seq;

    localparam int W  = 8;
    localparam int D  = 5;
    localparam int L  = 5;
    localparam int FW = W * D * D;
    localparam int TW = $clog2(D + 1);

    logic          clock = 1'b0;
    logic          reset, start, op, saturar;
    logic [TW-1:0] tamanho;
    logic [FW-1:0] mat_a, mat_b, res;
    logic          busy, done, overflow;

    typedef struct {
        logic [FW-1:0] m;
        logic          o;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    somador_matrizes_seq #(.ELEM_W(W), .DIM(D), .LANES(L)) dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .op               (op),
        .saturar          (saturar),
        .tamanho          (tamanho),
        .matriz_entrada_a (mat_a),
        .matriz_entrada_b (mat_b),
        .matriz_resultado (res),
        .busy             (busy),
        .done             (done),
        .overflow         (overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic over (coluna, linha)
    function automatic exp_t model(input logic [FW-1:0] ma, input logic [FW-1:0] mb,
                                   input logic o, input logic s, input logic [TW-1:0] t);
        exp_t e;
        int n, va, vb, v, k;
        int maxv, minv;
        logic [W-1:0] ea, eb;
        maxv = (1 << (W-1)) - 1;
        minv = -(1 << (W-1));
        e.m = '0;
        e.o = 1'b0;
        n = (t == 0 || int'(t) > D) ? D : int'(t);
        for (int coluna = 0; coluna < D; coluna++) begin
            for (int linha = 0; linha < D; linha++) begin
                k = linha + D * coluna;
                if (linha < n && coluna < n) begin
                    ea = ma[W*k +: W];
                    eb = mb[W*k +: W];
                    va = int'($signed(ea));
                    vb = int'($signed(eb));
                    v  = o ? va - vb : va + vb;
                    if (v > maxv || v < minv) begin
                        e.o = 1'b1;
                        if (s) v = (v > 0) ? maxv : minv;
                    end
                    e.m[W*k +: W] = v[W-1:0];
                end
            end
        end
        return e;
    endfunction

    function automatic logic [FW-1:0] fill(input logic [W-1:0] v);
        logic [FW-1:0] m;
        for (int k = 0; k < D*D; k++) m[W*k +: W] = v;
        return m;
    endfunction

    // Monitor: every done pulse must match the oldest pending expectation
    always @(negedge clock) begin
        exp_t e;
        if (!reset && done) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 expected no pending operation");
            end else begin
                e = sb.pop_front();
                check("result", res, e.m);
                check("overflow", {{(FW-1){1'b0}}, overflow}, {{(FW-1){1'b0}}, e.o});
            end
        end
    end

    task automatic run_op(input logic [FW-1:0] ma, input logic [FW-1:0] mb, input logic o,
                          input logic s, input logic [TW-1:0] t, input bit disturb);
        int busy_cnt = 0;
        int done_at  = 0;
        @(negedge clock);
        mat_a = ma; mat_b = mb; op = o; saturar = s; tamanho = t; start = 1'b1;
        sb.push_back(model(ma, mb, o, s, t));
        for (int c = 1; c <= 40 && done_at == 0; c++) begin
            @(negedge clock);
            start = 1'b0;
            if (disturb && c == 2) begin
                start = 1'b1;
                mat_a = ~ma;
                mat_b = ~mb;
                op = ~o;
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_at = c;
                if (disturb) start = 1'b1;
            end
        end
        check("busy_cycles", FW'(busy_cnt), FW'(32'd5));
        check("done_latency", FW'(done_at), FW'(32'd6));
        @(negedge clock);
        start = 1'b0;
        if (disturb) begin
            check("start_at_done_ignored", {{(FW-1){1'b0}}, busy}, {FW{1'b0}});
            @(negedge clock);
            check("no_second_op", {{(FW-1){1'b0}}, busy | done}, {FW{1'b0}});
        end
    endtask

    initial begin
        logic [FW-1:0] ra, rb;
        reset = 1'b1; start = 1'b0; op = 1'b0; saturar = 1'b0; tamanho = '0;
        mat_a = '0; mat_b = '0;
        repeat (3) @(negedge clock);
        check("reset_result", res, {FW{1'b0}});
        check("reset_flags", {{(FW-3){1'b0}}, busy, done, overflow}, {FW{1'b0}});
        reset = 1'b0;

        run_op(fill(8'd3),   fill(8'd4),   1'b0, 1'b0, 3'd5, 1'b0);
        run_op(fill(8'd100), fill(8'd100), 1'b0, 1'b0, 3'd5, 1'b0);
        run_op(fill(8'd100), fill(8'd100), 1'b0, 1'b1, 3'd5, 1'b0);
        run_op(fill(8'h9C),  fill(8'd100), 1'b1, 1'b1, 3'd5, 1'b0);
        run_op(fill(8'd5),   fill(8'd9),   1'b1, 1'b1, 3'd5, 1'b0);
        run_op(fill(8'd1),   fill(8'd1),   1'b0, 1'b0, 3'd3, 1'b0);
        run_op(fill(8'd1),   fill(8'd1),   1'b0, 1'b0, 3'd0, 1'b0);
        run_op(fill(8'd1),   fill(8'd1),   1'b0, 1'b0, 3'd7, 1'b0);

        for (int i = 0; i < 20; i++) begin
            for (int k = 0; k < D*D; k++) begin
                ra[W*k +: W] = W'($urandom);
                rb[W*k +: W] = W'($urandom);
            end
            run_op(ra, rb, 1'($urandom), 1'($urandom), TW'($urandom_range(0, 7)), 1'b0);
        end

        run_op(fill(8'd10), fill(8'd20), 1'b0, 1'b0, 3'd4, 1'b1);

        // Abort during CALC: nothing pending on the scoreboard for this one
        @(negedge clock);
        mat_a = fill(8'd7); mat_b = fill(8'd7); op = 1'b0; saturar = 1'b0; tamanho = 3'd5;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort_result", res, {FW{1'b0}});
        check("abort_flags", {{(FW-3){1'b0}}, busy, done, overflow}, {FW{1'b0}});
        repeat (8) @(negedge clock);
        check("abort_no_done", {{(FW-1){1'b0}}, done}, {FW{1'b0}});

        run_op(fill(8'h80), fill(8'd1), 1'b1, 1'b0, 3'd2, 1'b0);
        repeat (3) @(negedge clock);
        check("scoreboard_empty", FW'(sb.size()), {FW{1'b0}});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
